execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Pipeline execute stage directly upstream of the memory-access stage.
- Takes decoded operands and a 4-bit opcode from decode and computes ALU results or load/store addresses.
- Registers the outputs the memory-access stage consumes every cycle: control_ex, result_ex, reg_data_ex, dest_reg_index_ex, dest_reg_write_en_ex.
- Contains a multi-cycle iterative multiplier. While it runs, the stage stalls decode and inserts bubbles downstream.

Parameters:
- WIDTH, 16, datapath width; the memory-access interface requires 16.
- MUL_CYCLES, 16, multiplier iterations, one multiplier bit per cycle; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_id  in  1  decode presents a valid instruction.
- control_id  in  4  opcode.
- operand_a_id  in  16  source A.
- operand_b_id  in  16  source B or immediate.
- reg_data_id  in  16  store data.
- dest_reg_index_id  in  5  destination register.
- dest_reg_write_en_id  in  1  register-write request.
- flush_ex  in  1  kill the current and in-flight instruction.
- stall_ex  out  1  decode must hold its outputs unchanged.
- control_ex  out  4  registered opcode.
- result_ex  out  16  ALU result or memory address.
- reg_data_ex  out  16  registered store data.
- dest_reg_index_ex  out  5  registered destination.
- dest_reg_write_en_ex  out  1  registered write enable.

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT (~a).
  - 0110 SLL, 0111 SRL, 1000 SRA; shift amount is b[3:0].
  - 1001 MUL (low 16 bits of a*b).
  - 1010 SLT (signed a<b gives 1, else 0).
  - 1011 LUI (b<<8).
  - 1100 LOAD and 1110 STORE: result is a+b.
  - 1101 and 1111 NOP.
- Arithmetic: all arithmetic wraps mod 2^16; no flags.
- Reset values: control_ex=1111 (NOP), result_ex=0, reg_data_ex=0, dest_reg_index_ex=0, dest_reg_write_en_ex=0, stall_ex=0. Reset also forces state IDLE and count=0.
- Bubble: control_ex=1111, dest_reg_write_en_ex=0. result_ex, reg_data_ex and dest_reg_index_ex hold their previous values.
- Non-MUL ops take 1 cycle. Inputs are captured at the rising edge and appear on the outputs after that edge.
- valid_id=0 or an opcode of 1101/1111 produces a bubble.
- State machine, states IDLE and MUL_BUSY:
  - IDLE → MUL_BUSY when valid_id & control_id==1001 & !flush_ex. At that edge: latch a, b, dest index and dest write enable; set count=0; accumulator=0; output a bubble.
  - In MUL_BUSY, each edge: if multiplier bit b[count] is 1, add a<<count to the accumulator; then increment count.
  - Leaving MUL_BUSY: the edge where count==15 writes control_ex=1001, result_ex=accumulator, and the latched dest index/enable, then returns to IDLE. All other MUL_BUSY edges output bubbles.
  - stall_ex = (IDLE & valid_id & control_id==1001) | (MUL_BUSY & count!=15). It is combinational.
  - MUL latency is 17 edges from first presentation and produces 16 bubbles.
- Inputs are ignored while in MUL_BUSY. Decode advances at the edge ending the final busy cycle, so the MUL is never re-accepted.
- flush_ex (synchronous):
  - Outputs a bubble next edge.
  - MUL_BUSY → IDLE, count cleared.
  - stall_ex is forced to 0 in the same cycle.
  - reset dominates flush_ex.
- Reset during MUL_BUSY aborts the multiply with no result issued.
- Back-to-back MUL: the second MUL is accepted on the cycle after the first completes.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: iterative multiplier and state machine present, as above.
- Undefined: no state machine. Opcode 1001 is treated as NOP (bubble, write enable 0). stall_ex is tied to 0.

Decomposition:
- Shared package exec_pkg holds:
  - opcode localparams: OP_ADD through OP_NOP, including OP_LOAD=4'b1100 and OP_STORE=4'b1110, shared with memory access;
  - WIDTH;
  - the bubble control constant 4'b1111.
- One sub-module, iterative_multiplier:
  - start, a, b in; busy, done, product out.
  - Instantiated only under EXEC_MUL_EN.
- ALU stays combinational inside execute_stage.

Test Plan:
- ADD a=0xFFFF, b=0x0002, dest 5, write enable 1 → next cycle result_ex=0x0001, control_ex=0000, dest_reg_index_ex=5, dest_reg_write_en_ex=1.
- STORE a=0x0100, b=0x0010, reg_data=0xBEEF → result_ex=0x0110, reg_data_ex=0xBEEF, control_ex=1110.
- SRA a=0x8000, b=0x0003 → result_ex=0xF000; SLT a=0xFFFF, b=0x0001 → result_ex=0x0001.
- MUL a=0x0123, b=0x0045 → stall_ex high 16 cycles, 16 bubbles, then result_ex=0x4E6F, control_ex=1001; following ADD completes the next cycle.
- flush_ex asserted 5 cycles into MUL → stall_ex drops the same cycle, bubble out, no MUL result ever issued; reset mid-MUL → all outputs at reset values.
- Build without EXEC_MUL_EN, MUL a=3, b=4 → control_ex=1111, dest_reg_write_en_ex=0, stall_ex never high.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: definitions shared by the execute stage and its neighbours.
//   WIDTH        - datapath width (memory access expects 16)
//   OP_*         - 4-bit opcodes; OP_LOAD/OP_STORE are also decoded by memory access
//   CTRL_BUBBLE  - control value driven downstream for an empty slot
//   is_nop_op()  - true for both NOP encodings
package exec_pkg;

   localparam int WIDTH = 16;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_NOT   = 4'b0101;
   localparam logic [3:0] OP_SLL   = 4'b0110;
   localparam logic [3:0] OP_SRL   = 4'b0111;
   localparam logic [3:0] OP_SRA   = 4'b1000;
   localparam logic [3:0] OP_MUL   = 4'b1001;
   localparam logic [3:0] OP_SLT   = 4'b1010;
   localparam logic [3:0] OP_LUI   = 4'b1011;
   localparam logic [3:0] OP_LOAD  = 4'b1100;
   localparam logic [3:0] OP_NOP1  = 4'b1101;
   localparam logic [3:0] OP_STORE = 4'b1110;
   localparam logic [3:0] OP_NOP   = 4'b1111;

   localparam logic [3:0] CTRL_BUBBLE = 4'b1111;

   function automatic logic is_nop_op(input logic [3:0] op);
      return (op == OP_NOP1) || (op == OP_NOP);
   endfunction

endpackage

// File: rtl/execute_stage_multiplier.sv
// iterative_multiplier: shift-and-add multiplier, one multiplier bit per cycle.
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   abort        - drop any multiply in progress and return to idle
//   start        - latch a/b and begin (honoured only while idle)
//   a, b         - operands
//   busy         - a multiply is in progress
//   done         - final iteration cycle; product is valid this cycle only
//   product      - low WIDTH bits of a*b (valid while done)
module iterative_multiplier
   import exec_pkg::*;
#(
   parameter int WIDTH      = exec_pkg::WIDTH,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             abort,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_MUL_BUSY = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] sum;

   // The last iteration's partial product is folded in combinationally so the
   // full product is available on the same edge that leaves the busy state.
   always_comb begin
      partial = b_q[count_q] ? (a_q << count_q) : '0;
      sum     = acc_q + partial;
   end

   assign busy    = (state_q == S_MUL_BUSY);
   assign done    = busy && (count_q == LAST);
   assign product = sum;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_MUL_BUSY;
               a_d     = a;
               b_d     = b;
               count_d = '0;
               acc_d   = '0;
            end
         end
         default: begin
            acc_d   = sum;
            count_d = count_q + 1'b1;
            if (count_q == LAST) begin
               state_d = S_IDLE;
               count_d = '0;
            end
         end
      endcase
      if (abort) begin
         state_d = S_IDLE;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: pipeline execute stage feeding memory access.
// Computes ALU results / load-store addresses in one cycle and registers the
// outputs memory access consumes. With macro EXEC_MUL_EN defined, opcode MUL
// runs on an iterative multiplier for MUL_CYCLES cycles while decode is stalled
// and bubbles are issued; without it, MUL is treated as a NOP and stall_ex is 0.
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   valid_id, control_id, operand_a_id, operand_b_id, reg_data_id,
//   dest_reg_index_id, dest_reg_write_en_id
//                         - decoded instruction from decode
//   flush_ex              - kill current and in-flight instruction
//   stall_ex              - decode must hold its outputs
//   control_ex, result_ex, reg_data_ex, dest_reg_index_ex, dest_reg_write_en_ex
//                         - registered outputs to memory access
module execute_stage
   import exec_pkg::*;
#(
   parameter int WIDTH      = exec_pkg::WIDTH,
   parameter int MUL_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_id,
   input  logic [3:0]       control_id,
   input  logic [WIDTH-1:0] operand_a_id,
   input  logic [WIDTH-1:0] operand_b_id,
   input  logic [WIDTH-1:0] reg_data_id,
   input  logic [4:0]       dest_reg_index_id,
   input  logic             dest_reg_write_en_id,
   input  logic             flush_ex,
   output logic             stall_ex,
   output logic [3:0]       control_ex,
   output logic [WIDTH-1:0] result_ex,
   output logic [WIDTH-1:0] reg_data_ex,
   output logic [4:0]       dest_reg_index_ex,
   output logic             dest_reg_write_en_ex
);

   // One multiplier bit is consumed per iteration, so the iteration count has
   // to match the operand width.
   if (MUL_CYCLES != WIDTH) begin : g_bad_cfg
      $error("execute_stage: MUL_CYCLES must equal WIDTH");
   end

   logic [3:0]       control_q, control_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] reg_data_q, reg_data_d;
   logic [4:0]       dest_idx_q, dest_idx_d;
   logic             dest_we_q, dest_we_d;
   logic [WIDTH-1:0] alu_result;
   logic             issue;

   // ---------------------------------------------------------------- ALU
   always_comb begin
      alu_result = '0;
      case (control_id)
         OP_ADD:   alu_result = operand_a_id + operand_b_id;
         OP_SUB:   alu_result = operand_a_id - operand_b_id;
         OP_AND:   alu_result = operand_a_id & operand_b_id;
         OP_OR:    alu_result = operand_a_id | operand_b_id;
         OP_XOR:   alu_result = operand_a_id ^ operand_b_id;
         OP_NOT:   alu_result = ~operand_a_id;
         OP_SLL:   alu_result = operand_a_id << operand_b_id[3:0];
         OP_SRL:   alu_result = operand_a_id >> operand_b_id[3:0];
         OP_SRA:   alu_result = $signed(operand_a_id) >>> operand_b_id[3:0];
         OP_SLT:   alu_result = {{(WIDTH-1){1'b0}},
                                 ($signed(operand_a_id) < $signed(operand_b_id))};
         OP_LUI:   alu_result = operand_b_id << 8;
         OP_LOAD,
         OP_STORE: alu_result = operand_a_id + operand_b_id;
         default:  alu_result = '0;
      endcase
   end

`ifdef EXEC_MUL_EN
   // ---------------------------------------------------------- multiplier
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [4:0]       mul_idx_q, mul_idx_d;
   logic             mul_we_q, mul_we_d;

   // Only accepted from idle; inputs seen while busy are the stalled MUL itself.
   assign mul_start = valid_id && (control_id == OP_MUL) && !flush_ex && !mul_busy;

   iterative_multiplier #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .abort   (flush_ex),
      .start   (mul_start),
      .a       (operand_a_id),
      .b       (operand_b_id),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Stall drops in the final busy cycle so decode advances on the edge that
   // issues the product.
   always_comb begin
      stall_ex = (!mul_busy && valid_id && (control_id == OP_MUL)) ||
                 (mul_busy && !mul_done);
      if (flush_ex) stall_ex = 1'b0;
   end

   always_comb begin
      mul_idx_d = mul_idx_q;
      mul_we_d  = mul_we_q;
      if (mul_start) begin
         mul_idx_d = dest_reg_index_id;
         mul_we_d  = dest_reg_write_en_id;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mul_idx_q <= '0;
         mul_we_q  <= 1'b0;
      end else begin
         mul_idx_q <= mul_idx_d;
         mul_we_q  <= mul_we_d;
      end
   end
`else
   assign stall_ex = 1'b0;
`endif

   // ------------------------------------------------------- output stage
   // Bubbles only touch control and write enable; the data fields hold.
   always_comb begin
      control_d  = control_q;
      result_d   = result_q;
      reg_data_d = reg_data_q;
      dest_idx_d = dest_idx_q;
      dest_we_d  = dest_we_q;
      issue      = valid_id && !is_nop_op(control_id) && (control_id != OP_MUL);
      if (flush_ex) begin
         control_d = CTRL_BUBBLE;
         dest_we_d = 1'b0;
      end
`ifdef EXEC_MUL_EN
      else if (mul_done) begin
         control_d  = OP_MUL;
         result_d   = mul_product;
         dest_idx_d = mul_idx_q;
         dest_we_d  = mul_we_q;
      end else if (mul_busy) begin
         control_d = CTRL_BUBBLE;
         dest_we_d = 1'b0;
      end
`endif
      else if (issue) begin
         control_d  = control_id;
         result_d   = alu_result;
         reg_data_d = reg_data_id;
         dest_idx_d = dest_reg_index_id;
         dest_we_d  = dest_reg_write_en_id;
      end else begin
         control_d = CTRL_BUBBLE;
         dest_we_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         control_q  <= CTRL_BUBBLE;
         result_q   <= '0;
         reg_data_q <= '0;
         dest_idx_q <= '0;
         dest_we_q  <= 1'b0;
      end else begin
         control_q  <= control_d;
         result_q   <= result_d;
         reg_data_q <= reg_data_d;
         dest_idx_q <= dest_idx_d;
         dest_we_q  <= dest_we_d;
      end
   end

   assign control_ex           = control_q;
   assign result_ex            = result_q;
   assign reg_data_ex          = reg_data_q;
   assign dest_reg_index_ex    = dest_idx_q;
   assign dest_reg_write_en_ex = dest_we_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; MUL scenarios follow the EXEC_MUL_EN build.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_id;
   logic [3:0]  control_id;
   logic [15:0] operand_a_id;
   logic [15:0] operand_b_id;
   logic [15:0] reg_data_id;
   logic [4:0]  dest_reg_index_id;
   logic        dest_reg_write_en_id;
   logic        flush_ex;
   logic        stall_ex;
   logic [3:0]  control_ex;
   logic [15:0] result_ex;
   logic [15:0] reg_data_ex;
   logic [4:0]  dest_reg_index_ex;
   logic        dest_reg_write_en_ex;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk                  (clk),
      .reset                (reset),
      .valid_id             (valid_id),
      .control_id           (control_id),
      .operand_a_id         (operand_a_id),
      .operand_b_id         (operand_b_id),
      .reg_data_id          (reg_data_id),
      .dest_reg_index_id    (dest_reg_index_id),
      .dest_reg_write_en_id (dest_reg_write_en_id),
      .flush_ex             (flush_ex),
      .stall_ex             (stall_ex),
      .control_ex           (control_ex),
      .result_ex            (result_ex),
      .reg_data_ex          (reg_data_ex),
      .dest_reg_index_ex    (dest_reg_index_ex),
      .dest_reg_write_en_ex (dest_reg_write_en_ex)
   );

   // ALU vectors: opcode, a, b, expected result
   logic [3:0]  v_op  [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                               4'h7, 4'h8, 4'hA, 4'hA, 4'hB, 4'hC};
   logic [15:0] v_a   [13] = '{16'hFFFF, 16'h0003, 16'hF0F0, 16'h00F0, 16'hFFFF,
                               16'h00FF, 16'h0001, 16'h8000, 16'h8000, 16'hFFFF,
                               16'h0001, 16'h0000, 16'h0100};
   logic [15:0] v_b   [13] = '{16'h0002, 16'h0005, 16'h0FF0, 16'h0F00, 16'h00FF,
                               16'h1234, 16'h0014, 16'h000F, 16'h0003, 16'h0001,
                               16'hFFFF, 16'h12AB, 16'hFFF0};
   logic [15:0] v_exp [13] = '{16'h0001, 16'hFFFE, 16'h00F0, 16'h0FF0, 16'hFF00,
                               16'hFF00, 16'h0010, 16'h0001, 16'hF000, 16'h0001,
                               16'h0000, 16'hAB00, 16'h00F0};

   // Present one instruction at the falling edge.
   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] rd,
                        input logic [4:0] idx, input logic we);
      @(negedge clk);
      valid_id             = v;
      control_id           = op;
      operand_a_id         = a;
      operand_b_id         = b;
      reg_data_id          = rd;
      dest_reg_index_id    = idx;
      dest_reg_write_en_id = we;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      step();
      step();
      n_cmp++; if (control_ex !== 4'hF) begin n_fail++; $display("FAIL reset_control got %h want f", control_ex); end
      n_cmp++; if (result_ex !== 16'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result_ex); end
      n_cmp++; if (reg_data_ex !== 16'h0) begin n_fail++; $display("FAIL reset_reg_data got %h want 0", reg_data_ex); end
      n_cmp++; if (dest_reg_index_ex !== 5'd0) begin n_fail++; $display("FAIL reset_dest got %0d want 0", dest_reg_index_ex); end
      n_cmp++; if (dest_reg_write_en_ex !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", dest_reg_write_en_ex); end
      n_cmp++; if (stall_ex !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_ex); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Consecutive ALU ops, one per cycle.
   task automatic test_alu();
      for (int i = 0; i < 13; i++) begin
         logic [4:0] idx;
         logic       we;
         idx = (i == 0) ? 5'd5 : 5'(i * 3 + 1);
         we  = (i % 2 == 0);
         drive(1'b1, v_op[i], v_a[i], v_b[i], 16'h0, idx, we);
         step();
         n_cmp++; if (result_ex !== v_exp[i]) begin n_fail++; $display("FAIL alu%0d_result got %h want %h", i, result_ex, v_exp[i]); end
         n_cmp++; if (control_ex !== v_op[i]) begin n_fail++; $display("FAIL alu%0d_control got %h want %h", i, control_ex, v_op[i]); end
         n_cmp++; if (dest_reg_index_ex !== idx) begin n_fail++; $display("FAIL alu%0d_dest got %0d want %0d", i, dest_reg_index_ex, idx); end
         n_cmp++; if (dest_reg_write_en_ex !== we) begin n_fail++; $display("FAIL alu%0d_we got %b want %b", i, dest_reg_write_en_ex, we); end
      end
   endtask

   task automatic test_store();
      drive(1'b1, 4'hE, 16'h0100, 16'h0010, 16'hBEEF, 5'd4, 1'b0);
      step();
      n_cmp++; if (result_ex !== 16'h0110) begin n_fail++; $display("FAIL store_addr got %h want 0110", result_ex); end
      n_cmp++; if (reg_data_ex !== 16'hBEEF) begin n_fail++; $display("FAIL store_data got %h want beef", reg_data_ex); end
      n_cmp++; if (control_ex !== 4'hE) begin n_fail++; $display("FAIL store_control got %h want e", control_ex); end
   endtask

   // valid low, then a 1101 NOP: bubble with data fields held from the store.
   task automatic test_bubble();
      for (int k = 0; k < 2; k++) begin
         if (k == 0) drive(1'b0, 4'h0, 16'h0001, 16'h0001, 16'h1111, 5'd9, 1'b1);
         else        drive(1'b1, 4'hD, 16'h0001, 16'h0001, 16'h2222, 5'd9, 1'b1);
         step();
         n_cmp++; if (control_ex !== 4'hF) begin n_fail++; $display("FAIL bubble%0d_control got %h want f", k, control_ex); end
         n_cmp++; if (dest_reg_write_en_ex !== 1'b0) begin n_fail++; $display("FAIL bubble%0d_we got %b want 0", k, dest_reg_write_en_ex); end
         n_cmp++; if (result_ex !== 16'h0110) begin n_fail++; $display("FAIL bubble%0d_result_hold got %h want 0110", k, result_ex); end
         n_cmp++; if (reg_data_ex !== 16'hBEEF) begin n_fail++; $display("FAIL bubble%0d_reg_data_hold got %h want beef", k, reg_data_ex); end
         n_cmp++; if (dest_reg_index_ex !== 5'd4) begin n_fail++; $display("FAIL bubble%0d_dest_hold got %0d want 4", k, dest_reg_index_ex); end
      end
   endtask

   task automatic test_flush_alu();
      drive(1'b1, 4'h0, 16'h0001, 16'h0001, 16'h0, 5'd3, 1'b1);
      step();
      n_cmp++; if (result_ex !== 16'h0002) begin n_fail++; $display("FAIL flush_pre_result got %h want 0002", result_ex); end
      drive(1'b1, 4'h0, 16'h0005, 16'h0005, 16'h0, 5'd7, 1'b1);
      flush_ex = 1'b1;
      step();
      n_cmp++; if (control_ex !== 4'hF) begin n_fail++; $display("FAIL flush_alu_control got %h want f", control_ex); end
      n_cmp++; if (dest_reg_write_en_ex !== 1'b0) begin n_fail++; $display("FAIL flush_alu_we got %b want 0", dest_reg_write_en_ex); end
      n_cmp++; if (result_ex !== 16'h0002) begin n_fail++; $display("FAIL flush_alu_result_hold got %h want 0002", result_ex); end
      @(negedge clk);
      flush_ex = 1'b0;
      valid_id = 1'b0;
   endtask

`ifdef EXEC_MUL_EN
   // Present a MUL and hold it until the product issues (bounded).
   task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [4:0] idx,
                          output logic [15:0] res, output logic [4:0] dst, output logic wen,
                          output int stalls, output int bubbles, output logic done);
      stalls  = 0;
      bubbles = 0;
      done    = 1'b0;
      res     = 'x;
      dst     = 'x;
      wen     = 1'bx;
      drive(1'b1, 4'h9, a, b, 16'h0, idx, 1'b1);
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (stall_ex) stalls++;
         step();
         if (control_ex === 4'h9) begin
            done = 1'b1;
            res  = result_ex;
            dst  = dest_reg_index_ex;
            wen  = dest_reg_write_en_ex;
         end else if (control_ex === 4'hF && dest_reg_write_en_ex === 1'b0) begin
            bubbles++;
         end
         if (!done) @(negedge clk);
      end
   endtask

   task automatic test_mul();
      logic [15:0] res;
      logic [4:0]  dst;
      logic        wen;
      logic        done;
      int          stalls, bubbles;
      run_mul(16'h0123, 16'h0045, 5'd7, res, dst, wen, stalls, bubbles, done);
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL mul_timeout got %b want 1", done); end
      n_cmp++; if (res !== 16'h4E6F) begin n_fail++; $display("FAIL mul_result got %h want 4e6f", res); end
      n_cmp++; if (dst !== 5'd7) begin n_fail++; $display("FAIL mul_dest got %0d want 7", dst); end
      n_cmp++; if (wen !== 1'b1) begin n_fail++; $display("FAIL mul_we got %b want 1", wen); end
      n_cmp++; if (stalls != 16) begin n_fail++; $display("FAIL mul_stall_cycles got %0d want 16", stalls); end
      n_cmp++; if (bubbles != 16) begin n_fail++; $display("FAIL mul_bubbles got %0d want 16", bubbles); end
      drive(1'b1, 4'h0, 16'h0001, 16'h0002, 16'h0, 5'd8, 1'b1);
      #1;
      n_cmp++; if (stall_ex !== 1'b0) begin n_fail++; $display("FAIL post_mul_stall got %b want 0", stall_ex); end
      step();
      n_cmp++; if (control_ex !== 4'h0 || result_ex !== 16'h0003) begin n_fail++; $display("FAIL post_mul_add got %h/%h want 0/0003", control_ex, result_ex); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] res;
      logic [4:0]  dst;
      logic        wen;
      logic        done;
      int          stalls, bubbles;
      run_mul(16'h0003, 16'h0004, 5'd2, res, dst, wen, stalls, bubbles, done);
      n_cmp++; if (done !== 1'b1 || res !== 16'h000C) begin n_fail++; $display("FAIL b2b_first got %b/%h want 1/000c", done, res); end
      run_mul(16'h0005, 16'hFFFA, 5'd6, res, dst, wen, stalls, bubbles, done);
      n_cmp++; if (done !== 1'b1 || res !== 16'hFFE2) begin n_fail++; $display("FAIL b2b_second got %b/%h want 1/ffe2", done, res); end
      n_cmp++; if (stalls != 16 || bubbles != 16) begin n_fail++; $display("FAIL b2b_second_timing got %0d/%0d want 16/16", stalls, bubbles); end
      n_cmp++; if (dst !== 5'd6) begin n_fail++; $display("FAIL b2b_second_dest got %0d want 6", dst); end
      @(negedge clk);
      valid_id = 1'b0;
   endtask

   task automatic test_mul_flush();
      logic seen;
      drive(1'b1, 4'h9, 16'h0123, 16'h0045, 16'h0, 5'd9, 1'b1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++; if (stall_ex !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall got %b want 1", stall_ex); end
      flush_ex = 1'b1;
      #1;
      n_cmp++; if (stall_ex !== 1'b0) begin n_fail++; $display("FAIL flush_stall_drop got %b want 0", stall_ex); end
      step();
      n_cmp++; if (control_ex !== 4'hF || dest_reg_write_en_ex !== 1'b0) begin n_fail++; $display("FAIL flush_mul_bubble got %h/%b want f/0", control_ex, dest_reg_write_en_ex); end
      @(negedge clk);
      flush_ex = 1'b0;
      valid_id = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         step();
         if (control_ex === 4'h9) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_mul_no_result got %b want 0", seen); end
      n_cmp++; if (stall_ex !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got %b want 0", stall_ex); end
   endtask

   task automatic test_mul_reset();
      logic seen;
      drive(1'b1, 4'h9, 16'h0123, 16'h0045, 16'hAAAA, 5'd11, 1'b1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset    = 1'b1;
      valid_id = 1'b0;
      step();
      n_cmp++; if (control_ex !== 4'hF || result_ex !== 16'h0 || reg_data_ex !== 16'h0) begin n_fail++; $display("FAIL midmul_reset_data got %h/%h/%h want f/0/0", control_ex, result_ex, reg_data_ex); end
      n_cmp++; if (dest_reg_index_ex !== 5'd0 || dest_reg_write_en_ex !== 1'b0) begin n_fail++; $display("FAIL midmul_reset_dest got %0d/%b want 0/0", dest_reg_index_ex, dest_reg_write_en_ex); end
      n_cmp++; if (stall_ex !== 1'b0) begin n_fail++; $display("FAIL midmul_reset_stall got %b want 0", stall_ex); end
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         step();
         if (control_ex === 4'h9 || stall_ex === 1'b1) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midmul_reset_no_result got %b want 0", seen); end
   endtask
`else
   task automatic test_mul_disabled();
      logic stalled;
      drive(1'b1, 4'h9, 16'h0003, 16'h0004, 16'h0, 5'd2, 1'b1);
      #1;
      stalled = stall_ex;
      step();
      n_cmp++; if (control_ex !== 4'hF) begin n_fail++; $display("FAIL nomul_control got %h want f", control_ex); end
      n_cmp++; if (dest_reg_write_en_ex !== 1'b0) begin n_fail++; $display("FAIL nomul_we got %b want 0", dest_reg_write_en_ex); end
      repeat (4) begin
         @(negedge clk);
         #1;
         if (stall_ex !== 1'b0) stalled = 1'b1;
         step();
      end
      n_cmp++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL nomul_stall got %b want 0", stalled); end
      n_cmp++; if (control_ex !== 4'hF) begin n_fail++; $display("FAIL nomul_held_control got %h want f", control_ex); end
      @(negedge clk);
      valid_id = 1'b0;
   endtask
`endif

   initial begin
      reset                = 1'b1;
      valid_id             = 1'b0;
      control_id           = 4'h0;
      operand_a_id         = 16'h0;
      operand_b_id         = 16'h0;
      reg_data_id          = 16'h0;
      dest_reg_index_id    = 5'd0;
      dest_reg_write_en_id = 1'b0;
      flush_ex             = 1'b0;
      test_reset();
      test_alu();
      test_store();
      test_bubble();
      test_flush_alu();
`ifdef EXEC_MUL_EN
      test_mul();
      test_back_to_back();
      test_mul_flush();
      test_mul_reset();
`else
      test_mul_disabled();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
